// File: rtl/calc_result_formatter_if.sv
// -----------------------------------------------------------------------------
// calc_result_formatter_if
//
// Groups the producer-side and consumer-side handshake signals of the
// TRISC result formatter.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both high. A source holds valid and its
// payload stable until that edge. The formatter's in_ready is high only when
// it is idle. Its out_valid stays high, with the payload held, until
// out_ready is seen.
//
// Signals:
//   in_valid   producer has a two's-complement result on in_data
//   in_data    8-bit two's-complement ALU result
//   in_ready   formatter can accept a result
//   out_valid  formatted result available
//   out_ready  consumer accepts the formatted result
//   out_sign   1 = negative
//   out_hund   BCD hundreds digit (0-1)
//   out_tens   BCD tens digit
//   out_ones   BCD ones digit
//   out_min    input was 0x80 (-128)
//
// Modports:
//   slave   the formatter itself
//   master  the environment (producer plus consumer)
// -----------------------------------------------------------------------------
interface calc_result_formatter_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       out_sign;
    logic [3:0] out_hund;
    logic [3:0] out_tens;
    logic [3:0] out_ones;
    logic       out_min;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sign, out_hund, out_tens, out_ones,
               out_min
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sign, out_hund, out_tens, out_ones,
               out_min
    );
endinterface

// File: rtl/calc_result_formatter.sv
// -----------------------------------------------------------------------------
// calc_result_formatter
//
// Converts one 8-bit two's-complement ALU result into a sign flag plus three
// BCD digits for the display driver.
//
// The sequence for each result is:
//   1. Accept the result in IDLE.
//   2. Convert it to sign-magnitude in LOAD.
//   3. Run eight shift-add-3 (double-dabble) iterations in SHIFT.
//   4. Present the result in DONE until the consumer takes it.
//
// Only one conversion is in flight at a time.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        calc_result_formatter_if.slave (in/out handshakes and digits)
//   busy       high in any state other than IDLE (inverse of in_ready)
//   dbg_state  current FSM state encoding:
//              0 = IDLE, 1 = LOAD, 2 = SHIFT, 3 = DONE
// -----------------------------------------------------------------------------
module calc_result_formatter (
    input  logic                           clk,
    input  logic                           rst_n,
    calc_result_formatter_if.slave         bus,
    output logic                           busy,
    output logic [1:0]                     dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Working registers
    logic [7:0]  staged;      // captured input result
    logic        sign_q;      // sign of the result being converted
    logic        min_q;       // result was -128
    logic [7:0]  mag;         // magnitude, shifted out MSB first
    logic [11:0] bcd;         // hundreds/tens/ones accumulator
    logic [2:0]  cnt;         // iteration counter

    // Output registers (hold the last result after returning to IDLE)
    logic        out_sign_q;
    logic        out_min_q;
    logic [3:0]  out_hund_q;
    logic [3:0]  out_tens_q;
    logic [3:0]  out_ones_q;

    // -------------------------------------------------------------------------
    // Double-dabble helpers.
    //
    // dd_step adjusts a BCD nibble (+3 when >= 5), shifts it left by one, and
    // pulls in the carry from the digit below.
    //
    // dd_carry is the bit that nibble pushes into the digit above. After the
    // +3 adjustment, bit 3 is set exactly when the original nibble was >= 5.
    // That holds for every valid BCD digit.
    // -------------------------------------------------------------------------
    function automatic logic [3:0] dd_step(input logic [3:0] n, input logic lsb);
        logic [2:0] low;
        low = (n >= 4'd5) ? (n[2:0] + 3'd3) : n[2:0];
        return {low, lsb};
    endfunction

    function automatic logic dd_carry(input logic [3:0] n);
        return (n >= 4'd5);
    endfunction

    // -------------------------------------------------------------------------
    // Sign-magnitude conversion of the staged result.
    //
    // -128 has no 7-bit magnitude: the 7-bit negate wraps to zero.
    // That case is flagged and the magnitude is forced to 128.
    // -------------------------------------------------------------------------
    logic       ld_sign;
    logic [6:0] ld_mag7;
    logic       ld_min;
    logic [7:0] ld_mag;

    always_comb begin
        ld_sign = staged[7];
        ld_mag7 = (staged[6:0] ^ {7{ld_sign}}) + {6'd0, ld_sign};
        ld_min  = ld_sign & (staged[6:0] == 7'd0);
        ld_mag  = ld_min ? 8'd128 : {1'b0, ld_mag7};
    end

    // One double-dabble iteration applied to the working registers.
    logic [11:0] bcd_nxt;
    logic [7:0]  mag_nxt;

    always_comb begin
        bcd_nxt = {dd_step(bcd[11:8], dd_carry(bcd[7:4])),
                   dd_step(bcd[7:4],  dd_carry(bcd[3:0])),
                   dd_step(bcd[3:0],  mag[7])};
        mag_nxt = {mag[6:0], 1'b0};
    end

    // Handshake and FSM decode terms
    logic in_fire;
    logic out_fire;
    logic shift_last;

    assign in_fire    = (state == IDLE) && bus.in_valid;
    assign out_fire   = (state == DONE) && bus.out_ready;
    assign shift_last = (state == SHIFT) && (cnt == 3'd7);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_fire)    state_nxt = LOAD;
            LOAD:                    state_nxt = SHIFT;
            SHIFT:   if (shift_last) state_nxt = DONE;
            DONE:    if (out_fire)   state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staged     <= 8'd0;
            sign_q     <= 1'b0;
            min_q      <= 1'b0;
            mag        <= 8'd0;
            bcd        <= 12'd0;
            cnt        <= 3'd0;
            out_sign_q <= 1'b0;
            out_min_q  <= 1'b0;
            out_hund_q <= 4'd0;
            out_tens_q <= 4'd0;
            out_ones_q <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        staged <= bus.in_data;
                    end
                end

                LOAD: begin
                    sign_q <= ld_sign;
                    min_q  <= ld_min;
                    mag    <= ld_mag;
                    bcd    <= 12'd0;
                    cnt    <= 3'd0;
                end

                SHIFT: begin
                    bcd <= bcd_nxt;
                    mag <= mag_nxt;
                    cnt <= cnt + 3'd1;
                    // The outputs are loaded on the DONE entry edge.
                    // They take the final iteration's value directly, so
                    // they are valid as soon as out_valid rises.
                    if (shift_last) begin
                        out_sign_q <= sign_q;
                        out_min_q  <= min_q;
                        out_hund_q <= bcd_nxt[11:8];
                        out_tens_q <= bcd_nxt[7:4];
                        out_ones_q <= bcd_nxt[3:0];
                    end
                end

                default: begin
                    // DONE: hold everything until the consumer accepts.
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_sign  = out_sign_q;
    assign bus.out_min   = out_min_q;
    assign bus.out_hund  = out_hund_q;
    assign bus.out_tens  = out_tens_q;
    assign bus.out_ones  = out_ones_q;

    assign busy          = (state != IDLE);
    assign dbg_state     = state;

endmodule

// File: tb/tb_calc_result_formatter.sv
// -----------------------------------------------------------------------------
// tb_calc_result_formatter
//
// Directed bench for calc_result_formatter.
//
// Expected results come from an arithmetic reference (absolute value plus
// /10 and %10). They are pushed to exp_q when a result is sent. A negedge
// monitor pops and compares them whenever out_valid & out_ready.
//
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_calc_result_formatter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic [1:0] dbg_state;

    calc_result_formatter_if bus ();

    calc_result_formatter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int          tests = 0;
    int          fails = 0;
    logic [13:0] exp_q[$];
    int          acc_cyc[$];
    int          hs_cyc = 0;
    int          vw = 0;
    int          last_w = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {sign, min, hund, tens, ones}
    function automatic logic [13:0] model(input logic [7:0] d);
        int         v;
        int         a;
        logic       s;
        logic       m;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        v = int'($signed(d));
        a = (v < 0) ? -v : v;
        s = (v < 0);
        m = (d == 8'h80);
        h = 4'(a / 100);
        t = 4'((a / 10) % 10);
        o = 4'(a % 10);
        return {s, m, h, t, o};
    endfunction

    function automatic logic [13:0] observed();
        return {bus.out_sign, bus.out_min, bus.out_hund, bus.out_tens, bus.out_ones};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (bus.out_valid) begin
            vw++;
        end else if (vw != 0) begin
            last_w = vw;
            vw = 0;
        end
        if (bus.out_valid && bus.out_ready) begin
            acc_cyc.push_back(cyc);
            check("output_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                check("result", observed(), exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1. Returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [7:0] d, input bit expect_out);
        bit done;
        done = 1'b0;
        if (expect_out) exp_q.push_back(model(d));
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        hs_cyc       = cyc;
        bus.in_valid = 1'b0;
        check("accept_timeout", done, 1);
    endtask

    // Waits for out_valid and checks the 9-clock latency. Returns at a negedge.
    task automatic wait_valid(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check({tag, "_valid_seen"}, seen, 1);
        check({tag, "_latency"}, cyc - hs_cyc, 9);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit seen;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  bus.in_ready,  1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy",      busy,          0);
        check("rst_outputs",   observed(),    0);
        check("rst_state",     dbg_state,     0);
        rst_n = 1'b1;
        step();

        // Basic conversions, consumer always ready
        bus.out_ready = 1'b1;
        send(8'h00, 1);
        wait_valid("zero");
        check("zero_busy",     busy,         1);
        check("zero_in_ready", bus.in_ready, 0);
        step();
        send(8'h7F, 1); wait_valid("p127"); step();
        send(8'hFF, 1); wait_valid("m1");   step();
        send(8'h80, 1); wait_valid("m128"); step();
        send(8'h9C, 1); wait_valid("m100"); step();
        check("hold_after_idle_valid", bus.out_valid, 0);
        check("hold_after_idle_data",  observed(),    model(8'h9C));
        check("hold_after_idle_ready", bus.in_ready,  1);

        // Backpressure
        bus.out_ready = 1'b0;
        send(8'h2A, 1);
        wait_valid("bp");
        for (int i = 0; i < 6; i++) begin
            step();
            bus.in_valid = (i % 2 == 0);
            bus.in_data  = 8'h11;
            @(negedge clk);
            check("bp_valid",    bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready,  0);
            check("bp_busy",     busy,          1);
            check("bp_data",     observed(),    {1'b0, 1'b0, 4'd0, 4'd4, 4'd2});
        end
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready_same", bus.in_ready, 0);
        step();
        @(negedge clk);
        check("release_in_ready_next", bus.in_ready,  1);
        check("release_valid_drop",    bus.out_valid, 0);

        // Back-to-back stream, consumer tied ready
        step();
        acc_cyc.delete();
        send(8'h05, 1);
        send(8'hFB, 1);
        send(8'h64, 1);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("b2b_count",    acc_cyc.size(),        3);
        check("b2b_space_01", acc_cyc[1] - acc_cyc[0], 11);
        check("b2b_space_12", acc_cyc[2] - acc_cyc[1], 11);
        check("b2b_width",    last_w,                1);

        // Reset in the middle of SHIFT
        step();
        send(8'hC8, 0);
        repeat (5) @(posedge clk);
        #3;
        check("pre_reset_state", dbg_state, 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",    bus.out_valid, 0);
        check("mid_rst_in_ready", bus.in_ready,  1);
        check("mid_rst_busy",     busy,          0);
        check("mid_rst_outputs",  observed(),    0);
        check("mid_rst_state",    dbg_state,     0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("aborted_no_valid", seen, 0);
        step();
        send(8'h38, 1);
        wait_valid("after_rst");
        check("after_rst_data", observed(), {1'b0, 1'b0, 4'd0, 4'd5, 4'd6});
        step();
        step();

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
